// File: rtl/fx_regbank.sv
// fx bus register bank: cfg R/W, live status, sticky events with mask/W1C, event counter.
// Optional FX_REGBANK_SHADOW_EN: cfg writes land in shadows, committed via address 0x02.
module fx_regbank #(
    parameter int         N_CFG    = 8,
    parameter logic [7:0] CFG_BASE = 8'h80,
    parameter int         N_STS    = 4,
    parameter logic [7:0] STS_BASE = 8'h40,
    parameter logic [7:0] VERSION  = 8'h02
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic [15:0]        fx_waddr,
    input  logic               fx_wr,
    input  logic [7:0]         fx_data,
    input  logic [15:0]        fx_raddr,
    input  logic               fx_rd,
    output logic [7:0]         fx_q,
    output logic               fx_qv,
    input  logic [5:0]         mod_id,
    output logic [8*N_CFG-1:0] cfg_out,
    output logic [N_CFG-1:0]   cfg_wstb,
    input  logic [8*N_STS-1:0] sts_in,
    input  logic [7:0]         evt_in,
    output logic               irq
);

    localparam logic [7:0] A_ID     = 8'h00;
    localparam logic [7:0] A_VER    = 8'h01;
    localparam logic [7:0] A_COMMIT = 8'h02;
    localparam logic [7:0] A_FLAG   = 8'h10;
    localparam logic [7:0] A_MASK   = 8'h11;
    localparam logic [7:0] A_CNT    = 8'h12;

    logic       wr_en;
    logic       rd_en;
    logic [7:0] wa;
    logic [7:0] ra;
    logic       unused_hi;

    assign wr_en     = fx_wr && (fx_waddr[13:8] == mod_id);
    assign rd_en     = fx_rd && (fx_raddr[13:8] == mod_id);
    assign wa        = fx_waddr[7:0];
    assign ra        = fx_raddr[7:0];
    assign unused_hi = ^{fx_waddr[15:14], fx_raddr[15:14]};

    logic [N_CFG-1:0][7:0] cfg_q, cfg_d;
    logic [N_CFG-1:0][7:0] rd_cfg;
    logic [N_CFG-1:0]      wstb_q, wstb_d;
    logic [N_STS-1:0][7:0] sts;
    logic [7:0]            flag_q, flag_d;
    logic [7:0]            mask_q, mask_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            rdata_q, rdata_d;
    logic                  qv_q, qv_d;
    logic                  irq_q, irq_d;
    logic [7:0]            clr;
    logic                  rise;

    assign sts = sts_in;

`ifdef FX_REGBANK_SHADOW_EN
    logic [N_CFG-1:0][7:0] shd_q, shd_d;
    logic                  commit;

    assign commit = wr_en && (wa == A_COMMIT) && fx_data[0];
    assign rd_cfg = shd_q;

    always_comb begin
        shd_d  = shd_q;
        cfg_d  = cfg_q;
        wstb_d = '0;
        for (int i = 0; i < N_CFG; i++) begin
            if (wr_en && (wa == 8'(CFG_BASE + i)))
                shd_d[i] = fx_data;
            if (commit) begin
                cfg_d[i]  = shd_q[i];
                wstb_d[i] = (shd_q[i] != cfg_q[i]);
            end
        end
    end
`else
    assign rd_cfg = cfg_q;

    always_comb begin
        cfg_d  = cfg_q;
        wstb_d = '0;
        for (int i = 0; i < N_CFG; i++) begin
            if (wr_en && (wa == 8'(CFG_BASE + i))) begin
                cfg_d[i]  = fx_data;
                wstb_d[i] = 1'b1;
            end
        end
    end
`endif

    // New events win over a same-cycle W1C; counter clear wins over a rise.
    always_comb begin
        clr    = (wr_en && (wa == A_FLAG)) ? fx_data : 8'h00;
        flag_d = (flag_q & ~clr) | evt_in;
        rise   = |(flag_d & ~flag_q);
        mask_d = (wr_en && (wa == A_MASK)) ? fx_data : mask_q;
        if (wr_en && (wa == A_CNT))
            cnt_d = 8'h00;
        else if (rise && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'h01;
        else
            cnt_d = cnt_q;
        irq_d = |(flag_q & mask_q);
    end

    always_comb begin
        rdata_d = 8'h00;
        qv_d    = rd_en;
        if (rd_en) begin
            unique case (1'b1)
                (ra == A_ID):   rdata_d = {2'b00, mod_id};
                (ra == A_VER):  rdata_d = VERSION;
                (ra == A_FLAG): rdata_d = flag_q;
                (ra == A_MASK): rdata_d = mask_q;
                (ra == A_CNT):  rdata_d = cnt_q;
                default:        rdata_d = 8'h00;
            endcase
            for (int j = 0; j < N_STS; j++)
                if (ra == 8'(STS_BASE + j))
                    rdata_d = sts[j];
            for (int i = 0; i < N_CFG; i++)
                if (ra == 8'(CFG_BASE + i))
                    rdata_d = rd_cfg[i];
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CFG; i++) begin
                cfg_q[i] <= 8'(CFG_BASE + i);
`ifdef FX_REGBANK_SHADOW_EN
                shd_q[i] <= 8'(CFG_BASE + i);
`endif
            end
            wstb_q  <= '0;
            flag_q  <= 8'h00;
            mask_q  <= 8'h00;
            cnt_q   <= 8'h00;
            rdata_q <= 8'h00;
            qv_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
`ifdef FX_REGBANK_SHADOW_EN
            shd_q   <= shd_d;
`endif
            wstb_q  <= wstb_d;
            flag_q  <= flag_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            qv_q    <= qv_d;
            irq_q   <= irq_d;
        end
    end

    assign fx_q     = rdata_q;
    assign fx_qv    = qv_q;
    assign cfg_out  = cfg_q;
    assign cfg_wstb = wstb_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_fx_regbank.sv
// Directed bench for fx_regbank (default params, mod_id 0x05).
// Shadow scenarios compile in when FX_REGBANK_SHADOW_EN is defined.
module tb_fx_regbank;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [15:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic [15:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q;
    logic        fx_qv;
    logic [5:0]  mod_id;
    logic [63:0] cfg_out;
    logic [7:0]  cfg_wstb;
    logic [31:0] sts_in;
    logic [7:0]  evt_in;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [63:0] cfg_rst;
    logic [7:0]  q;
    logic        v;

    fx_regbank dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .fx_waddr (fx_waddr),
        .fx_wr    (fx_wr),
        .fx_data  (fx_data),
        .fx_raddr (fx_raddr),
        .fx_rd    (fx_rd),
        .fx_q     (fx_q),
        .fx_qv    (fx_qv),
        .mod_id   (mod_id),
        .cfg_out  (cfg_out),
        .cfg_wstb (cfg_wstb),
        .sts_in   (sts_in),
        .evt_in   (evt_in),
        .irq      (irq)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        fx_waddr = a;
        fx_data  = d;
        fx_wr    = 1'b1;
        @(negedge clk_sys);
        fx_wr    = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [7:0] rq, output logic rv);
        @(negedge clk_sys);
        fx_raddr = a;
        fx_rd    = 1'b1;
        @(negedge clk_sys);
        fx_rd    = 1'b0;
        rq = fx_q;
        rv = fx_qv;
    endtask

    task automatic test_reset;
        checks++;
        if (cfg_out !== cfg_rst) begin
            errors++;
            $display("FAIL rst_cfg got %h exp %h", cfg_out, cfg_rst);
        end
        checks++;
        if ({fx_q, fx_qv, irq, cfg_wstb} !== 18'h0) begin
            errors++;
            $display("FAIL rst_out got q=%h qv=%b irq=%b wstb=%h exp 0",
                     fx_q, fx_qv, irq, cfg_wstb);
        end
    endtask

    task automatic test_id_reads;
        for (int i = 0; i < 8; i++) begin
            do_read(16'h0580 + 16'(i), q, v);
            checks++;
            if ({v, q} !== {1'b1, 8'h80 + 8'(i)}) begin
                errors++;
                $display("FAIL cfg_rd%0d got qv=%b q=%h exp qv=1 q=%h",
                         i, v, q, 8'h80 + 8'(i));
            end
        end
        do_read(16'h0500, q, v);
        checks++;
        if ({v, q} !== 9'h105) begin
            errors++;
            $display("FAIL id_rd got qv=%b q=%h exp qv=1 q=05", v, q);
        end
        do_read(16'h0501, q, v);
        checks++;
        if ({v, q} !== 9'h102) begin
            errors++;
            $display("FAIL ver_rd got qv=%b q=%h exp qv=1 q=02", v, q);
        end
        @(negedge clk_sys);
        checks++;
        if ({fx_qv, fx_q} !== 9'h0) begin
            errors++;
            $display("FAIL rd_idle got qv=%b q=%h exp 0", fx_qv, fx_q);
        end
    endtask

`ifndef FX_REGBANK_SHADOW_EN
    task automatic test_cfg_write;
        do_write(16'h0583, 8'h5A);
        checks++;
        if ({cfg_out[31:24], cfg_wstb} !== {8'h5A, 8'h08}) begin
            errors++;
            $display("FAIL cfg_wr got cfg3=%h wstb=%h exp 5a 08",
                     cfg_out[31:24], cfg_wstb);
        end
        @(negedge clk_sys);
        checks++;
        if (cfg_wstb !== 8'h00) begin
            errors++;
            $display("FAIL wstb_1cyc got %h exp 00", cfg_wstb);
        end
        do_read(16'h0583, q, v);
        checks++;
        if ({v, q} !== 9'h15A) begin
            errors++;
            $display("FAIL cfg_rdback got qv=%b q=%h exp qv=1 q=5a", v, q);
        end
        do_write(16'h0683, 8'h11);
        checks++;
        if ({cfg_out[31:24], cfg_wstb} !== {8'h5A, 8'h00}) begin
            errors++;
            $display("FAIL other_mod_wr got cfg3=%h wstb=%h exp 5a 00",
                     cfg_out[31:24], cfg_wstb);
        end
        do_read(16'h0683, q, v);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL other_mod_rd got qv=%b exp 0", v);
        end
        do_write(16'h0502, 8'h01);
        checks++;
        if ({cfg_out, cfg_wstb} !== {cfg_rst[63:32], 8'h5A, cfg_rst[23:0], 8'h00}) begin
            errors++;
            $display("FAIL unmapped_wr got cfg=%h wstb=%h", cfg_out, cfg_wstb);
        end
        // read and write of the same register in one cycle
        @(negedge clk_sys);
        fx_raddr = 16'h0584;
        fx_rd    = 1'b1;
        fx_waddr = 16'h0584;
        fx_data  = 8'h77;
        fx_wr    = 1'b1;
        @(negedge clk_sys);
        fx_rd = 1'b0;
        fx_wr = 1'b0;
        checks++;
        if ({fx_qv, fx_q, cfg_out[39:32]} !== {1'b1, 8'h84, 8'h77}) begin
            errors++;
            $display("FAIL rd_wr_same got qv=%b q=%h cfg4=%h exp 1 84 77",
                     fx_qv, fx_q, cfg_out[39:32]);
        end
    endtask
`endif

    task automatic test_events;
        do_write(16'h0511, 8'h04);
        @(negedge clk_sys);
        evt_in = 8'h04;
        @(negedge clk_sys);
        evt_in = 8'h00;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_lag1 got %b exp 0", irq);
        end
        @(negedge clk_sys);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_lag2 got %b exp 1", irq);
        end
        do_read(16'h0510, q, v);
        checks++;
        if ({v, q} !== 9'h104) begin
            errors++;
            $display("FAIL flag_rd got qv=%b q=%h exp 1 04", v, q);
        end
        do_read(16'h0512, q, v);
        checks++;
        if ({v, q} !== 9'h101) begin
            errors++;
            $display("FAIL cnt_rd1 got qv=%b q=%h exp 1 01", v, q);
        end
        do_write(16'h0510, 8'h04);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold got %b exp 1", irq);
        end
        @(negedge clk_sys);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr got %b exp 0", irq);
        end
        evt_in = 8'h04;
        do_write(16'h0510, 8'h04);
        evt_in = 8'h00;
        do_read(16'h0510, q, v);
        checks++;
        if (q !== 8'h04) begin
            errors++;
            $display("FAIL set_wins got %h exp 04", q);
        end
        do_read(16'h0512, q, v);
        checks++;
        if (q !== 8'h02) begin
            errors++;
            $display("FAIL cnt_rd2 got %h exp 02", q);
        end
        do_write(16'h0510, 8'h04);
        do_read(16'h0510, q, v);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL flag_w1c got %h exp 00", q);
        end
    endtask

    task automatic test_saturation;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_sys);
            evt_in = 8'h01;
            @(negedge clk_sys);
            evt_in = 8'h00;
            do_write(16'h0510, 8'h01);
        end
        do_read(16'h0512, q, v);
        checks++;
        if (q !== 8'hFF) begin
            errors++;
            $display("FAIL cnt_sat got %h exp ff", q);
        end
        do_write(16'h0512, 8'hA5);
        do_read(16'h0512, q, v);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL cnt_clr got %h exp 00", q);
        end
        @(negedge clk_sys);
        evt_in   = 8'h02;
        fx_waddr = 16'h0512;
        fx_data  = 8'h00;
        fx_wr    = 1'b1;
        @(negedge clk_sys);
        evt_in = 8'h00;
        fx_wr  = 1'b0;
        do_read(16'h0512, q, v);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL cnt_clr_wins got %h exp 00", q);
        end
        do_read(16'h0510, q, v);
        checks++;
        if (q !== 8'h02) begin
            errors++;
            $display("FAIL flag_bit1 got %h exp 02", q);
        end
        do_write(16'h0510, 8'hFF);
    endtask

    task automatic test_status;
        sts_in = 32'h12C3_C35A;
        sts_in[15:8] = 8'hC3;
        do_read(16'h0541, q, v);
        checks++;
        if ({v, q} !== 9'h1C3) begin
            errors++;
            $display("FAIL sts1 got qv=%b q=%h exp 1 c3", v, q);
        end
        sts_in = 32'h1234_C356;
        do_read(16'h0540, q, v);
        checks++;
        if (q !== 8'h56) begin
            errors++;
            $display("FAIL sts0 got %h exp 56", q);
        end
        do_read(16'h0543, q, v);
        checks++;
        if (q !== 8'h12) begin
            errors++;
            $display("FAIL sts3 got %h exp 12", q);
        end
        do_read(16'h0544, q, v);
        checks++;
        if ({v, q} !== 9'h100) begin
            errors++;
            $display("FAIL sts_oob got qv=%b q=%h exp 1 00", v, q);
        end
        do_read(16'h05FF, q, v);
        checks++;
        if ({v, q} !== 9'h100) begin
            errors++;
            $display("FAIL unmapped_rd got qv=%b q=%h exp 1 00", v, q);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk_sys);
        fx_raddr = 16'h0580;
        fx_rd    = 1'b1;
        @(negedge clk_sys);
        checks++;
        if ({fx_qv, fx_q} !== 9'h180) begin
            errors++;
            $display("FAIL b2b0 got qv=%b q=%h exp 1 80", fx_qv, fx_q);
        end
        fx_raddr = 16'hC581;
        @(negedge clk_sys);
        checks++;
        if ({fx_qv, fx_q} !== 9'h181) begin
            errors++;
            $display("FAIL b2b1 got qv=%b q=%h exp 1 81", fx_qv, fx_q);
        end
        fx_raddr = 16'h0501;
        @(negedge clk_sys);
        checks++;
        if ({fx_qv, fx_q} !== 9'h102) begin
            errors++;
            $display("FAIL b2b2 got qv=%b q=%h exp 1 02", fx_qv, fx_q);
        end
        fx_rd = 1'b0;
        @(negedge clk_sys);
        checks++;
        if ({fx_qv, fx_q} !== 9'h000) begin
            errors++;
            $display("FAIL b2b_end got qv=%b q=%h exp 0 00", fx_qv, fx_q);
        end
    endtask

`ifdef FX_REGBANK_SHADOW_EN
    task automatic test_shadow;
        do_write(16'h0581, 8'h33);
        checks++;
        if ({cfg_out, cfg_wstb} !== {cfg_rst, 8'h00}) begin
            errors++;
            $display("FAIL shd_hold got cfg=%h wstb=%h", cfg_out, cfg_wstb);
        end
        do_read(16'h0581, q, v);
        checks++;
        if ({v, q} !== 9'h133) begin
            errors++;
            $display("FAIL shd_rd got qv=%b q=%h exp 1 33", v, q);
        end
        do_write(16'h0583, 8'h83);
        do_write(16'h0502, 8'h01);
        checks++;
        if ({cfg_out, cfg_wstb} !== {cfg_rst[63:16], 8'h33, 8'h80, 8'h02}) begin
            errors++;
            $display("FAIL commit got cfg=%h wstb=%h exp slice1=33 wstb=02",
                     cfg_out, cfg_wstb);
        end
        @(negedge clk_sys);
        checks++;
        if (cfg_wstb !== 8'h00) begin
            errors++;
            $display("FAIL commit_wstb got %h exp 00", cfg_wstb);
        end
    endtask
`endif

    task automatic test_mid_reset;
        do_write(16'h0511, 8'hFF);
        @(negedge clk_sys);
        fx_raddr = 16'h0580;
        fx_rd    = 1'b1;
        fx_waddr = 16'h0586;
        fx_data  = 8'h55;
        fx_wr    = 1'b1;
        evt_in   = 8'hFF;
        @(posedge clk_sys);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_out, cfg_wstb, fx_q, fx_qv, irq} !== {cfg_rst, 18'h0}) begin
            errors++;
            $display("FAIL mid_rst got cfg=%h wstb=%h q=%h qv=%b irq=%b",
                     cfg_out, cfg_wstb, fx_q, fx_qv, irq);
        end
        @(negedge clk_sys);
        fx_rd  = 1'b0;
        fx_wr  = 1'b0;
        evt_in = 8'h00;
        @(negedge clk_sys);
        rst_n = 1'b1;
        do_read(16'h0510, q, v);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL rst_flag got %h exp 00", q);
        end
        do_read(16'h0511, q, v);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL rst_mask got %h exp 00", q);
        end
        do_read(16'h0512, q, v);
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL rst_cnt got %h exp 00", q);
        end
        do_read(16'h0581, q, v);
        checks++;
        if (q !== 8'h81) begin
            errors++;
            $display("FAIL rst_cfg1 got %h exp 81", q);
        end
    endtask

    initial begin
        cfg_rst  = 64'h8786_8584_8382_8180;
        rst_n    = 1'b0;
        fx_waddr = 16'h0;
        fx_wr    = 1'b0;
        fx_data  = 8'h0;
        fx_raddr = 16'h0;
        fx_rd    = 1'b0;
        mod_id   = 6'h05;
        sts_in   = 32'h0;
        evt_in   = 8'h0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        test_reset();
        test_id_reads();
`ifndef FX_REGBANK_SHADOW_EN
        test_cfg_write();
`endif
        test_events();
        test_saturation();
        test_status();
        test_back_to_back();
`ifdef FX_REGBANK_SHADOW_EN
        test_shadow();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx_regbank.md
# fx_regbank

Parametrised register bank slave for the fx bus; next generation of the per-module configuration register slave. Provides N_CFG read/write configuration registers, N_STS read-only live status registers, an 8-bit sticky event/interrupt block with mask and write-1-to-clear, and a saturating event counter. Sits inside each functional top (pack, etc.) and is selected by `mod_id`. Read data comes with a valid strobe.

## Interface
- N_CFG, 8, number of configuration registers (1..64)
- CFG_BASE, 8'h80, low-byte address of cfg register 0
- N_STS, 4, number of status registers (1..16)
- STS_BASE, 8'h40, low-byte address of status register 0
- VERSION, 8'h02, value returned at address 0x01

- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fx_waddr  in  16  write address; [13:8] module select, [7:0] register
- fx_wr  in  1  write strobe, one cycle
- fx_data  in  8  write data
- fx_raddr  in  16  read address, same split
- fx_rd  in  1  read strobe, one cycle
- fx_q  out  8  read data
- fx_qv  out  1  fx_q valid
- mod_id  in  6  module id
- cfg_out  out  8*N_CFG  cfg register i at bits [8i+7:8i]
- cfg_wstb  out  N_CFG  one-cycle pulse when cfg_out slice i is updated
- sts_in  in  8*N_STS  live status, sampled at read
- evt_in  in  8  event inputs, level-sensitive
- irq  out  1  registered interrupt

## Operation
- Select: wsel = (fx_waddr[13:8]==mod_id), rsel likewise; bits [15:14] ignored.
- Map: 0x00 R {2'b00,mod_id}; 0x01 R VERSION; 0x02 W commit (shadow build only); 0x10 evt_flag R/W1C; 0x11 evt_mask R/W; 0x12 evt_cnt R, any write clears; STS_BASE+j R sts_in slice j; CFG_BASE+i R/W cfg i.
- Ranges must not overlap and must end at or below 0xFF.
- Unmapped writes are ignored. Unmapped selected reads return 0x00 with fx_qv=1.
- evt_flag[k] set in any cycle evt_in[k]=1. Cleared by writing 1 to bit k of 0x10. Simultaneous set and clear: set wins.
- evt_cnt increments by 1 in each cycle where at least one evt_flag bit goes 0->1. Saturates at 0xFF. A clear-write in the same cycle wins; result 0x00.
- irq <= |(evt_flag & evt_mask), evaluated on the register values before the edge.

## Timing
- Reset values: cfg i = (CFG_BASE+i)[7:0]; evt_flag, evt_mask, evt_cnt = 0; fx_q = 0; fx_qv = 0; irq = 0; cfg_wstb = 0.
- Write: register updates on the edge where fx_wr=1. cfg_wstb[i] is high the following cycle, aligned with the new cfg_out.
- Read: one-cycle latency. fx_q and fx_qv are valid the cycle after fx_rd; otherwise fx_q=0 and fx_qv=0.
- A read and a write to the same register in the same cycle return the pre-write value.
- sts_in is sampled on the fx_rd edge.
- irq lags its causing evt_in by 2 cycles: flag set, then irq.
- Back-to-back reads every cycle are supported, one result per cycle.
- Reset mid-operation clears all state immediately; no pending strobes survive.

## Configuration
- FX_REGBANK_SHADOW_EN defined:
  - cfg writes go to shadow registers; reads at CFG_BASE+i return the shadow value.
  - Writing 0x02 with bit0=1 copies all shadows to cfg_out on that edge.
  - cfg_wstb then pulses for every slice whose value changed.
  - Shadow reset values equal the cfg reset values.
- FX_REGBANK_SHADOW_EN undefined:
  - no shadow; cfg_out updates directly on write; 0x02 is unmapped.

## Test plan
- Reset, mod_id=6'h05, N_CFG=8, CFG_BASE=8'h80, VERSION=8'h02. Read 0x0580..0x0587 -> 0x80..0x87 with fx_qv=1; read 0x0500 -> 0x05; read 0x0501 -> 0x02.
- Write 0x0583=0x5A, then read 0x0583 -> 0x5A; cfg_out[31:24]=0x5A; cfg_wstb[3] pulses for exactly 1 cycle. Write 0x0683=0x11 -> no change; read 0x0683 -> fx_qv stays 0.
- evt_mask=0x04; pulse evt_in[2] for one cycle -> evt_flag=0x04, evt_cnt=1, irq=1 two cycles after the pulse. Write 0x10=0x04 -> irq=0 the cycle after the flag clears. Hold evt_in[2]=1 while writing 0x04 -> flag stays 1.
- Generate 300 separate flag set/clear cycles -> evt_cnt=0xFF. Write 0x12 -> evt_cnt=0x00.
- sts_in slice 1 = 0xC3; read STS_BASE+1 -> 0xC3. Read 0x05FF -> 0x00 with fx_qv=1.
- Shadow build: write 0x0581=0x33 -> cfg_out unchanged, readback 0x33. Write 0x0502=0x01 -> cfg_out slice 1=0x33 and only cfg_wstb[1] pulses. Assert rst_n mid-sequence -> all outputs return to reset values.
